// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } spi_state_e;

  // Command field carried in the top two bits of a received word.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned RX_BITS = DEFAULT_ADDR_WIDTH + 2;

  // Received word width: two command bits plus the address/data byte.
  function automatic int unsigned rx_bits(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-to-serial read-data shifter: armed by the FSM, loads on tx_valid,
// shifts MSB first and flags done once the whole byte has been driven.
module spi_tx_shifter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             arm,
  input  logic             tx_valid,
  input  logic [Width-1:0] tx_data,
  output logic             miso,
  output logic             done
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic             armed_q;
  logic             active_q;
  logic             done_q;
  logic [Width-1:0] sreg_q;
  logic [CntW-1:0]  cnt_q;

  // Arm, load, shift and retire the outgoing byte; clear drops everything.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      armed_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      sreg_q   <= '0;
      cnt_q    <= '0;
    end else if (arm) begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (armed_q && tx_valid) begin
      // Bit 7 is on the line right after the loading edge.
      sreg_q   <= tx_data;
      active_q <= 1'b1;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (cnt_q == CntW'(Width - 1)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        sreg_q <= {sreg_q[Width-2:0], 1'b0};
        cnt_q  <= cnt_q + CntW'(1);
      end
    end
  end

  // Line is low unless a byte is actively being shifted.
  always_comb begin
    miso = active_q & sreg_q[Width-1];
    done = done_q;
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: frame FSM and receive shift register, with the
// read-data return path delegated to spi_tx_shifter.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADDR_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [ADDR_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int unsigned RxBits = rx_bits(ADDR_WIDTH);
  localparam int unsigned CntW   = $clog2(RxBits);

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RxBits-2:0] shift_q, shift_d;
  logic [RxBits-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              addr_seen_q, addr_seen_d;
  // Set once a word has been taken in this frame so extra bits are ignored.
  logic              word_done_q, word_done_d;
  logic              tx_arm;
  logic              tx_clear;
  logic              tx_miso;
  logic              tx_done;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      addr_seen_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addr_seen_q <= addr_seen_d;
      word_done_q <= word_done_d;
    end
  end

  // Next-state logic: command check, 10-bit word capture, frame abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addr_seen_d = addr_seen_q;
    word_done_d = word_done_q;
    tx_arm      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d       = '0;
        word_done_d = 1'b0;
        if (!ss_n) begin
          state_d = StChkCmd;
        end
      end

      StChkCmd: begin
        cnt_d = '0;
        if (ss_n) begin
          state_d = StIdle;
        end else if (!mosi) begin
          state_d = StWrite;
        end else if (addr_seen_q) begin
          state_d = StReadData;
        end else begin
          state_d = StReadAdd;
        end
      end

      StWrite, StReadAdd, StReadData: begin
        if (!word_done_q) begin
          if (cnt_q == CntW'(RxBits - 1)) begin
            // Capture even if ss_n rises on this same edge.
            rx_data_d   = {shift_q, mosi};
            rx_valid_d  = 1'b1;
            cnt_d       = '0;
            word_done_d = 1'b1;
            if (state_q == StReadAdd) begin
              addr_seen_d = 1'b1;
            end
            if (state_q == StReadData) begin
              addr_seen_d = 1'b0;
              tx_arm      = 1'b1;
            end
          end else begin
            shift_d = {shift_q[RxBits-3:0], mosi};
            cnt_d   = cnt_q + CntW'(1);
          end
        end
        if (ss_n) begin
          state_d     = StIdle;
          cnt_d       = '0;
          word_done_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Deselect wipes any pending or in-flight read data.
  always_comb begin
    tx_clear = ss_n;
  end

  spi_tx_shifter #(
    .Width (ADDR_WIDTH)
  ) u_tx_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (tx_clear),
    .arm      (tx_arm),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .miso     (tx_miso),
    .done     (tx_done)
  );

  // Registered outputs; hold the line low once the byte is out.
  always_comb begin
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    miso     = tx_miso & ~tx_done;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: received words go through a scoreboard
// queue, read data is checked bit by bit on miso.
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int unsigned n_checks;
  int unsigned n_fails;
  logic [9:0]  sb_q[$];
  logic        prev_valid;

  spi_slave #(
    .ADDR_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid pops one expected word; pulses must be one cycle.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      check_eq("rx_pulse_width", {31'd0, prev_valid}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("rx_unexpected", {31'd0, rx_valid}, 32'd0);
      end else begin
        check_eq("rx_data", {22'd0, rx_data}, {22'd0, sb_q.pop_front()});
      end
    end
    prev_valid <= rx_valid;
  end

  // Start a frame and shift nbits of word; tx_valid is raised for bit indices tv_lo..tv_hi.
  task automatic drive_word(input logic d, input logic [9:0] word, input int nbits,
                            input logic rel_last, input int tv_lo, input int tv_hi);
    if (nbits == 10) sb_q.push_back(word);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    mosi = d;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      mosi     = word[9-k];
      tx_valid = (k >= tv_lo) && (k <= tv_hi);
      if (rel_last && k == 9) ss_n = 1'b1;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("state_idle", {29'd0, dut.state_q}, {29'd0, StIdle});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx_byte;
    n_checks   = 0;
    n_fails    = 0;
    prev_valid = 1'b0;
    rst        = 1'b1;
    ss_n       = 1'b1;
    mosi       = 1'b0;
    tx_data    = 8'h5A;
    tx_valid   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rx_data", {22'd0, rx_data}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_miso", {31'd0, miso}, 32'd0);
    check_eq("rst_state", {29'd0, dut.state_q}, {29'd0, StIdle});
    check_eq("rst_addr_seen", {31'd0, dut.addr_seen_q}, 32'd0);
    rst = 1'b0;

    // Write address and write data frames.
    drive_word(1'b0, 10'h0A5, 10, 1'b0, -1, -1);
    end_frame();
    check_eq("wr_addr_hold", {22'd0, rx_data}, 32'h0A5);
    drive_word(1'b0, 10'h1F0, 10, 1'b0, -1, -1);
    end_frame();

    // Reset after 5 data bits must discard the word and clear rx_data.
    drive_word(1'b0, 10'h2CC, 5, 1'b0, -1, -1);
    @(negedge clk);
    rst  = 1'b1;
    ss_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("midrst_miso", {31'd0, miso}, 32'd0);
    check_eq("midrst_state", {29'd0, dut.state_q}, {29'd0, StIdle});
    check_eq("midrst_rx_data", {22'd0, rx_data}, 32'd0);
    rst = 1'b0;

    // ss_n rises with the 10th bit: word still captured.
    drive_word(1'b0, 10'h155, 10, 1'b1, -1, -1);
    end_frame();

    // Read address frame sets addr_seen.
    drive_word(1'b1, 10'h203, 10, 1'b0, -1, -1);
    end_frame();
    check_eq("addr_seen_set", {31'd0, dut.addr_seen_q}, 32'd1);

    // Aborted write after 4 bits: no strobe, rx_data and addr_seen kept.
    drive_word(1'b0, 10'h0FF, 4, 1'b0, -1, -1);
    end_frame();
    check_eq("abort_rx_data", {22'd0, rx_data}, 32'h203);
    check_eq("abort_addr_seen", {31'd0, dut.addr_seen_q}, 32'd1);

    // Read data frame; early tx_valid during bits 4..5 must be ignored.
    drive_word(1'b1, 10'h3AB, 10, 1'b0, 4, 5);
    check_eq("early_tx_miso", {31'd0, miso}, 32'd0);
    @(negedge clk);
    check_eq("armed_miso_0", {31'd0, miso}, 32'd0);
    check_eq("addr_seen_clr", {31'd0, dut.addr_seen_q}, 32'd0);
    @(negedge clk);
    check_eq("armed_miso_1", {31'd0, miso}, 32'd0);
    tx_byte  = 8'hC3;
    tx_data  = tx_byte;
    tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      check_eq($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, tx_byte[i]});
      tx_valid = 1'b0;
      tx_data  = 8'hFF;
    end
    repeat (2) begin
      @(negedge clk);
      check_eq("miso_after", {31'd0, miso}, 32'd0);
    end
    end_frame();
    check_eq("final_rx_data", {22'd0, rx_data}, 32'h3AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
